// File: rtl/booth_pkg.sv
// Radix-4 Booth digit encoding shared by the partial-product array and its row generator.
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_P1,
    BD_P2,
    BD_M1,
    BD_M2
  } booth_digit_t;

  function automatic booth_digit_t booth_encode(input logic [2:0] triple);
    case (triple)
      3'b001, 3'b010: return BD_P1;
      3'b011:         return BD_P2;
      3'b100:         return BD_M2;
      3'b101, 3'b110: return BD_M1;
      default:        return BD_ZERO;
    endcase
  endfunction

  function automatic int npp(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: selects 0, +-y or +-2y from a 3-bit window of x.
module booth_pp_row
  import booth_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   triple_i,
  input  logic [W+1:0] y_ext_i,
  output logic [W+1:0] pp_o,
  output logic         neg_o
);

  booth_digit_t digit;
  logic [W+1:0] mag;

  // Negative digits are emitted as one's complement; the +1 travels on neg_o.
  always_comb begin
    digit = booth_encode(triple_i);
    mag   = '0;
    neg_o = 1'b0;
    case (digit)
      BD_P1: mag = y_ext_i;
      BD_P2: mag = {y_ext_i[W:0], 1'b0};
      BD_M1: begin
        mag   = y_ext_i;
        neg_o = 1'b1;
      end
      BD_M2: begin
        mag   = {y_ext_i[W:0], 1'b0};
        neg_o = 1'b1;
      end
      default: mag = '0;
    endcase
    pp_o = neg_o ? ~mag : mag;
  end

endmodule

// File: rtl/booth_pp_array.sv
// Full radix-4 Booth partial-product array behind a PIPE-deep elastic valid/ready pipeline.
module booth_pp_array
  import booth_pkg::*;
#(
  parameter int W    = 16,
  parameter int PIPE = 1,
  parameter int TAGW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          x,
  input  logic [W-1:0]          y,
  input  logic                  is_signed,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W/2:0][W+1:0]   pp,
  output logic [W/2:0]          neg,
  output logic [TAGW-1:0]       out_tag
);

  localparam int NPP = npp(W);

  typedef logic [NPP-1:0][W+1:0] pp_arr_t;

  if (W < 4 || (W % 2) != 0 || PIPE < 0 || PIPE > 4) begin : g_param_err
    $error("booth_pp_array: W must be even and >= 4, PIPE must be 0..4");
  end

  logic [W+1:0]   x_ext;
  logic [W+1:0]   y_ext;
  logic [W+2:0]   x_win;
  pp_arr_t        pp_c;
  logic [NPP-1:0] neg_c;

  assign x_ext = {{2{is_signed & x[W-1]}}, x};
  assign y_ext = {{2{is_signed & y[W-1]}}, y};
  assign x_win = {x_ext, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_row
    booth_pp_row #(.W(W)) u_row (
      .triple_i (x_win[2*i+2 -: 3]),
      .y_ext_i  (y_ext),
      .pp_o     (pp_c[i]),
      .neg_o    (neg_c[i])
    );
  end

  // Index 0 is the combinational array; index k+1 is the output of register stage k.
  logic            v_s   [PIPE+1];
  logic            rdy_s [PIPE+1];
  pp_arr_t         pp_s  [PIPE+1];
  logic [NPP-1:0]  neg_s [PIPE+1];
  logic [TAGW-1:0] tag_s [PIPE+1];

  assign v_s[0]   = in_valid;
  assign pp_s[0]  = pp_c;
  assign neg_s[0] = neg_c;
  assign tag_s[0] = in_tag;

  always_comb begin
    rdy_s[PIPE] = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      rdy_s[k] = !v_s[k+1] || rdy_s[k+1];
    end
  end

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    logic            v_q, v_d;
    pp_arr_t         pp_q, pp_d;
    logic [NPP-1:0]  neg_q, neg_d;
    logic [TAGW-1:0] tag_q, tag_d;

    always_comb begin
      v_d   = v_q;
      pp_d  = pp_q;
      neg_d = neg_q;
      tag_d = tag_q;
      if (rdy_s[k]) begin
        v_d = v_s[k];
        if (v_s[k]) begin
          pp_d  = pp_s[k];
          neg_d = neg_s[k];
          tag_d = tag_s[k];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        pp_q  <= '0;
        neg_q <= '0;
        tag_q <= '0;
      end else begin
        v_q   <= v_d;
        pp_q  <= pp_d;
        neg_q <= neg_d;
        tag_q <= tag_d;
      end
    end

    assign v_s[k+1]   = v_q;
    assign pp_s[k+1]  = pp_q;
    assign neg_s[k+1] = neg_q;
    assign tag_s[k+1] = tag_q;
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = v_s[PIPE];
  assign pp        = pp_s[PIPE];
  assign neg       = neg_s[PIPE];
  assign out_tag   = tag_s[PIPE];

endmodule

// File: doc/booth_pp_array.md
Name: booth_pp_array

Overview:
Parametrised successor to the single-row binary partial-product generator. Produces the full radix-4 Booth partial-product array for multiplier x and multiplicand y, with runtime signed/unsigned mode. Output passes through a PIPE-deep elastic valid/ready pipeline with tag pass-through. Feeds the compression tree of the fast multiplier.

Parameters:
W, 16, operand width; even, ≥4.
PIPE, 1, register stages between input and output; 0..4. 0 = combinational pass-through.
TAGW, 4, width of the sideband tag carried with each operation.
NPP, W/2+1, number of partial-product rows (derived; not overridable).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input operation valid
in_ready  out  1  block can accept an input this cycle
x  in  W  multiplier (Booth-recoded)
y  in  W  multiplicand
is_signed  in  1  1 = two's-complement operands; 0 = unsigned
in_tag  in  TAGW  sideband tag
out_valid  out  1  output array valid
out_ready  in  1  consumer accepts output
pp  out  NPP×(W+2)  partial-product rows; row i has weight 4^i
neg  out  NPP  per-row +1 correction bit; weight 4^i
out_tag  out  TAGW  tag of the output operation

Behaviour:
- Transfer occurs on a clock edge where valid&&ready. Inputs are sampled only on an input transfer.
- Extension rules:
  - x_ext (W+2 bits) = is_signed ? sign-extend(x) : zero-extend(x); bit x_ext[-1] = 0.
  - y_ext (W+2 bits) extends y by the same rule.
- Digit i (i = 0..NPP-1) is taken from {x_ext[2i+1], x_ext[2i], x_ext[2i-1]}:
  - 000, 111 → 0
  - 001, 010 → +1
  - 011 → +2
  - 100 → -2
  - 101, 110 → -1
- Row formation:
  - m = |d|·y_ext, truncated to W+2 bits (2·y_ext is a 1-bit left shift).
  - pp[i] = (d<0) ? ~m : m.
  - neg[i] = (d<0).
  - A 0 digit gives pp = 0, neg = 0.
- Invariant: Σ (sext(pp[i]) + neg[i])·4^i mod 2^(2W) == x·y, computed in the selected signedness.
- Pipeline stages:
  - Each stage holds {valid, pp, neg, tag}.
  - Stage k loads when !valid_k || ready_(k+1); the last stage's ready_(k+1) is out_ready.
  - in_ready = ready into stage 0. The combinational ready chain is permitted.
  - Full throughput: one operation per cycle when out_ready = 1.
  - Latency: exactly PIPE cycles from input transfer to out_valid.
- Stall: while out_ready = 0, pp/neg/out_tag/out_valid are held stable. After PIPE accepted operations with no drain, in_ready = 0. No loss, no duplication, order preserved.
- Simultaneous input and output transfer when full: both occur in the same cycle and occupancy is unchanged.
- PIPE = 0: out_valid = in_valid, in_ready = out_ready, outputs are combinational from inputs.
- Reset (any cycle, including mid-stream):
  - All stage valid bits and data registers are cleared to 0.
  - Next cycle: out_valid = 0, pp = 0, neg = 0, out_tag = 0, in_ready = 1.
  - In-flight operations are discarded.
- is_signed is registered with the operation and does not affect operations already in the pipeline.

Decomposition:
- Package booth_pkg contains:
  - enum booth_digit_t {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2}
  - function booth_encode(3-bit) → booth_digit_t
  - function npp(W) = W/2+1
- Sub-module booth_pp_row (combinational): inputs triple, y_ext; outputs pp row and neg. Instantiated NPP times via generate.
- The elastic stage is implemented inline in a generate loop.

Test Plan:
1. W=8, unsigned, x=0x03, y=0x05 → pp0=0x3FA, neg0=1; pp1=0x005, neg1=0; rows 2–4 = 0, neg = 0; weighted sum = 15.
2. W=8, signed, x=0x80, y=0x80 → only row 3 is nonzero: pp3=0x0FF, neg3=1; weighted sum = 0x4000.
3. W=8, unsigned, x=0xFF, y=0xFF, plus 1000 random x/y/is_signed/tag operations → every weighted sum equals the reference product mod 2^16, and out_tag matches.
4. PIPE=2, hold out_ready=0 while driving in_valid=1 → exactly 2 operations accepted, then in_ready=0. Release out_ready → outputs appear in order with tags 0,1,2…; no gaps, no duplicates.
5. Mid-stream reset with 2 operations in flight → cycle after reset: out_valid=0, in_ready=1, pp=0. A new operation issued next emerges after PIPE cycles.
6. PIPE=0, toggle out_ready each cycle → in_ready mirrors out_ready combinationally; outputs are valid in the same cycle as the input transfer.
